// File: rtl/axi_arb_pkg.sv
// ----------------------------------------------------------------------------
// axi_arb_pkg
// Shared definitions for the two-master AXI arbiters: FSM state encoding,
// master tags carried in the upper bits of the slave-side ID, response codes
// and a helper that maps a grant index to its master tag.
// ----------------------------------------------------------------------------
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        ERR   = 3'd3,
        DRAIN = 3'd4
    } arb_state_e;

    localparam logic [3:0] MTAG_M0 = 4'd0;
    localparam logic [3:0] MTAG_M1 = 4'd1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Master tag prepended to ARID on the slave side.
    function automatic logic [3:0] mtag(input logic gnt_id);
        logic [3:0] tag_v;
        if (gnt_id) begin
            tag_v = MTAG_M1;
        end else begin
            tag_v = MTAG_M0;
        end
        return tag_v;
    endfunction

endpackage

// File: rtl/rr_picker2.sv
// ----------------------------------------------------------------------------
// rr_picker2
// Two-requester round-robin picker, purely combinational. A lone requester
// wins outright; when both request, the one named by prio wins.
// Ports:
//   req[1:0]   request vector (bit n = requester n)
//   prio       favoured requester when both request
//   gnt_valid  some requester is granted
//   gnt_id     index of the granted requester
// ----------------------------------------------------------------------------
module rr_picker2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Grant selection.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                gnt_id    = prio;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_id    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter
// Two-master to one-slave AXI read-path (AR + R) arbiter. Round-robin grant,
// one outstanding burst; the grant is held from the AR handshake until the
// last R beat has been handed to its owner.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   AR*_M0 / AR*_M1                  master read-address channels
//   R*_M0  / R*_M1                   master read-data channels
//   AR*_S                            slave read-address channel (ARID_S = {tag, ARID})
//   R*_S                             slave read-data channel
// Optional build macro:
//   ARB_TIMEOUT_EN  enables a MAX_WAIT-cycle watchdog over ADDR+DATA that
//                   answers the owner with one DECERR beat and then drains
//                   any late slave beats.
// ----------------------------------------------------------------------------
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    // master 0
    input  logic [ID_W-1:0]   ARID_M0,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [3:0]        ARLEN_M0,
    input  logic [2:0]        ARSIZE_M0,
    input  logic [1:0]        ARBURST_M0,
    input  logic              ARVALID_M0,
    output logic              ARREADY_M0,
    output logic [ID_W-1:0]   RID_M0,
    output logic [DATA_W-1:0] RDATA_M0,
    output logic [1:0]        RRESP_M0,
    output logic              RLAST_M0,
    output logic              RVALID_M0,
    input  logic              RREADY_M0,
    // master 1
    input  logic [ID_W-1:0]   ARID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [3:0]        ARLEN_M1,
    input  logic [2:0]        ARSIZE_M1,
    input  logic [1:0]        ARBURST_M1,
    input  logic              ARVALID_M1,
    output logic              ARREADY_M1,
    output logic [ID_W-1:0]   RID_M1,
    output logic [DATA_W-1:0] RDATA_M1,
    output logic [1:0]        RRESP_M1,
    output logic              RLAST_M1,
    output logic              RVALID_M1,
    input  logic              RREADY_M1,
    // slave
    output logic [ID_W+3:0]   ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [3:0]        ARLEN_S,
    output logic [2:0]        ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic              ARVALID_S,
    input  logic              ARREADY_S,
    input  logic [ID_W+3:0]   RID_S,
    input  logic [DATA_W-1:0] RDATA_S,
    input  logic [1:0]        RRESP_S,
    input  logic              RLAST_S,
    input  logic              RVALID_S,
    output logic              RREADY_S
);

    arb_state_e        state_r, state_nxt_s;
    logic              prio_r;
    logic              owner_r;
    logic              gnt_valid_s;
    logic              gnt_id_s;
    logic              ar_hs_s;

    logic [3:0]        ar_tag_r;
    logic [ID_W-1:0]   ar_id_r;
    logic [ADDR_W-1:0] ar_addr_r;
    logic [3:0]        ar_len_r;
    logic [2:0]        ar_size_r;
    logic [1:0]        ar_burst_r;

    // Owner-side R beat before it is steered to one master.
    logic              route_s;
    logic              r_vld_s;
    logic [ID_W-1:0]   r_id_s;
    logic [DATA_W-1:0] r_data_s;
    logic [1:0]        r_resp_s;
    logic              r_last_s;
    logic              own_rready_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [9:0] WAIT_LIM = 10'(MAX_WAIT - 1);
    logic [9:0] wait_cnt_r;
    logic       addr_abort_r;
    logic       timeout_s;
    assign timeout_s = (wait_cnt_r == WAIT_LIM);
`endif

    rr_picker2 u_pick (
        .req       ({ARVALID_M1, ARVALID_M0}),
        .prio      (prio_r),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    assign own_rready_s = owner_r ? RREADY_M1 : RREADY_M0;

    // Slave AR fields always reflect the captured request; only ARVALID_S is gated.
    assign ARID_S    = {ar_tag_r, ar_id_r};
    assign ARADDR_S  = ar_addr_r;
    assign ARLEN_S   = ar_len_r;
    assign ARSIZE_S  = ar_size_r;
    assign ARBURST_S = ar_burst_r;

    // Next-state decode and handshake / routing outputs.
    always_comb begin
        state_nxt_s = state_r;
        ar_hs_s     = 1'b0;
        ARREADY_M0  = 1'b0;
        ARREADY_M1  = 1'b0;
        ARVALID_S   = 1'b0;
        RREADY_S    = 1'b0;
        route_s     = 1'b0;
        r_vld_s     = 1'b0;
        r_id_s      = {ID_W{1'b0}};
        r_data_s    = {DATA_W{1'b0}};
        r_resp_s    = RESP_OKAY;
        r_last_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // rst gating keeps ARREADY low while reset is asserted.
                if (!rst && gnt_valid_s) begin
                    ar_hs_s     = 1'b1;
                    ARREADY_M0  = ~gnt_id_s;
                    ARREADY_M1  = gnt_id_s;
                    state_nxt_s = ADDR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR: begin
                ARVALID_S = 1'b1;
                if (ARREADY_S) begin
                    state_nxt_s = DATA;
`ifdef ARB_TIMEOUT_EN
                end else if (timeout_s) begin
                    state_nxt_s = ERR;
`endif
                end else begin
                    state_nxt_s = ADDR;
                end
            end
            DATA: begin
                route_s  = 1'b1;
                r_vld_s  = RVALID_S;
                r_id_s   = RID_S[ID_W-1:0];
                r_data_s = RDATA_S;
                r_resp_s = RRESP_S;
                r_last_s = RLAST_S;
                RREADY_S = own_rready_s;
                if (RVALID_S && own_rready_s && RLAST_S) begin
                    state_nxt_s = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (timeout_s) begin
                    state_nxt_s = ERR;
`endif
                end else begin
                    state_nxt_s = DATA;
                end
            end
`ifdef ARB_TIMEOUT_EN
            ERR: begin
                route_s  = 1'b1;
                r_vld_s  = 1'b1;
                r_id_s   = ar_id_r;
                r_resp_s = RESP_DECERR;
                r_last_s = 1'b1;
                if (own_rready_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ERR;
                end
            end
            DRAIN: begin
                // No AR reached the slave when the timeout fired in ADDR, so nothing to drain.
                if (addr_abort_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    RREADY_S = 1'b1;
                    if (RVALID_S && RLAST_S) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Steer the owner-side beat to its master; the other master sees zeros.
    always_comb begin
        RVALID_M0 = 1'b0;
        RID_M0    = {ID_W{1'b0}};
        RDATA_M0  = {DATA_W{1'b0}};
        RRESP_M0  = 2'b00;
        RLAST_M0  = 1'b0;
        RVALID_M1 = 1'b0;
        RID_M1    = {ID_W{1'b0}};
        RDATA_M1  = {DATA_W{1'b0}};
        RRESP_M1  = 2'b00;
        RLAST_M1  = 1'b0;
        if (route_s && !owner_r) begin
            RVALID_M0 = r_vld_s;
            RID_M0    = r_id_s;
            RDATA_M0  = r_data_s;
            RRESP_M0  = r_resp_s;
            RLAST_M0  = r_last_s;
        end else if (route_s && owner_r) begin
            RVALID_M1 = r_vld_s;
            RID_M1    = r_id_s;
            RDATA_M1  = r_data_s;
            RRESP_M1  = r_resp_s;
            RLAST_M1  = r_last_s;
        end else begin
            RVALID_M0 = 1'b0;
            RVALID_M1 = 1'b0;
        end
    end

    // State, round-robin pointer, owner and captured AR request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            prio_r     <= 1'b0;
            owner_r    <= 1'b0;
            ar_tag_r   <= 4'd0;
            ar_id_r    <= {ID_W{1'b0}};
            ar_addr_r  <= {ADDR_W{1'b0}};
            ar_len_r   <= 4'd0;
            ar_size_r  <= 3'd0;
            ar_burst_r <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if (ar_hs_s) begin
                owner_r    <= gnt_id_s;
                ar_tag_r   <= mtag(gnt_id_s);
                ar_id_r    <= gnt_id_s ? ARID_M1    : ARID_M0;
                ar_addr_r  <= gnt_id_s ? ARADDR_M1  : ARADDR_M0;
                ar_len_r   <= gnt_id_s ? ARLEN_M1   : ARLEN_M0;
                ar_size_r  <= gnt_id_s ? ARSIZE_M1  : ARSIZE_M0;
                ar_burst_r <= gnt_id_s ? ARBURST_M1 : ARBURST_M0;
            end
            // Favour the other master once a burst is finished.
            if ((state_r != IDLE) && (state_nxt_s == IDLE)) begin
                prio_r <= ~owner_r;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter over ADDR+DATA and record of where it fired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r   <= 10'd0;
            addr_abort_r <= 1'b0;
        end else begin
            if (ar_hs_s) begin
                wait_cnt_r   <= 10'd0;
                addr_abort_r <= 1'b0;
            end else if ((state_r == ADDR) || (state_r == DATA)) begin
                wait_cnt_r <= wait_cnt_r + 10'd1;
                if ((state_r == ADDR) && (state_nxt_s == ERR)) begin
                    addr_abort_r <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Directed self-checking bench for axi_rd_arbiter. Inputs change on the
// falling clock edge, outputs are compared on the falling edge (+#1 where an
// input was just changed). With ARB_TIMEOUT_EN defined the DUT is built with
// MAX_WAIT = 16 and the watchdog sequence is exercised as well.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   ARID_M0, ARID_M1, RID_M0, RID_M1;
    logic [ADDR_W-1:0] ARADDR_M0, ARADDR_M1, ARADDR_S;
    logic [3:0]        ARLEN_M0, ARLEN_M1, ARLEN_S;
    logic [2:0]        ARSIZE_M0, ARSIZE_M1, ARSIZE_S;
    logic [1:0]        ARBURST_M0, ARBURST_M1, ARBURST_S;
    logic              ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
    logic [DATA_W-1:0] RDATA_M0, RDATA_M1, RDATA_S;
    logic [1:0]        RRESP_M0, RRESP_M1, RRESP_S;
    logic              RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
    logic              RREADY_M0, RREADY_M1;
    logic [ID_W+3:0]   ARID_S, RID_S;
    logic              ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
        .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0),
        .ARREADY_M0(ARREADY_M0), .RID_M0(RID_M0), .RDATA_M0(RDATA_M0),
        .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0), .RVALID_M0(RVALID_M0),
        .RREADY_M0(RREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1),
        .ARREADY_M1(ARREADY_M1), .RID_M1(RID_M1), .RDATA_M1(RDATA_M1),
        .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1), .RVALID_M1(RVALID_M1),
        .RREADY_M1(RREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
        .ARREADY_S(ARREADY_S), .RID_S(RID_S), .RDATA_S(RDATA_S),
        .RRESP_S(RRESP_S), .RLAST_S(RLAST_S), .RVALID_S(RVALID_S),
        .RREADY_S(RREADY_S)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ar(input bit m, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len);
        if (m) begin
            ARID_M1 = id; ARADDR_M1 = addr; ARLEN_M1 = len;
            ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'd1; ARVALID_M1 = 1'b1;
        end else begin
            ARID_M0 = id; ARADDR_M0 = addr; ARLEN_M0 = len;
            ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1; ARVALID_M0 = 1'b1;
        end
    endtask

    // Grant check in IDLE, then the request as seen on the slave AR channel.
    task automatic grant_phase(input bit m, input logic [3:0] id, input logic [31:0] addr);
        logic [7:0] exp_id;
        exp_id = {3'b000, m, id};
        #1;
        check("arready_granted", m ? ARREADY_M1 : ARREADY_M0, 64'd1);
        check("arready_other",   m ? ARREADY_M0 : ARREADY_M1, 64'd0);
        cyc();
        if (m) ARVALID_M1 = 1'b0; else ARVALID_M0 = 1'b0;
        check("arvalid_s", ARVALID_S, 64'd1);
        check("arid_s",    ARID_S,    64'(exp_id));
        check("araddr_s",  ARADDR_S,  64'(addr));
    endtask

    task automatic addr_accept();
        ARREADY_S = 1'b1;
        cyc();
        ARREADY_S = 1'b0;
    endtask

    // n beats, all accepted; RLAST on the final one when last_final is set.
    task automatic r_beats(input bit m, input int n, input logic [31:0] dbase,
                           input bit last_final, input logic [3:0] id);
        for (int b = 0; b < n; b++) begin
            RVALID_S = 1'b1;
            RDATA_S  = dbase + 32'(b);
            RLAST_S  = last_final && (b == n - 1);
            RID_S    = {3'b000, m, id};
            RRESP_S  = 2'b00;
            #1;
            check("rvalid_owner", m ? RVALID_M1 : RVALID_M0, 64'd1);
            check("rdata_owner",  m ? RDATA_M1  : RDATA_M0,  64'(dbase + 32'(b)));
            check("rlast_owner",  m ? RLAST_M1  : RLAST_M0,  64'(last_final && (b == n - 1)));
            check("rid_owner",    m ? RID_M1    : RID_M0,    64'(id));
            check("rvalid_other", m ? RVALID_M0 : RVALID_M1, 64'd0);
            check("rdata_other",  m ? RDATA_M0  : RDATA_M1,  64'd0);
            cyc();
        end
        RVALID_S = 1'b0;
        RLAST_S  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        int k;
        bit hs;
        rst = 1'b1;
        ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = '0; ARBURST_M0 = '0;
        ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = '0; ARBURST_M1 = '0;
        ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b0;
        RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        ARREADY_S = 1'b0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0;
        RVALID_S = 1'b1;
        cyc();
        cyc();
        // Reset state; requests and stray slave beats must be ignored.
        check("rst_arready_m0", ARREADY_M0, 64'd0);
        check("rst_arvalid_s",  ARVALID_S,  64'd0);
        check("rst_rready_s",   RREADY_S,   64'd0);
        check("rst_rvalid_m0",  RVALID_M0,  64'd0);
        check("rst_arid_s",     ARID_S,     64'd0);
        check("rst_araddr_s",   ARADDR_S,   64'd0);
        ARVALID_M0 = 1'b0;
        rst = 1'b0;
        cyc();
        #1;
        check("idle_rready_s_stray", RREADY_S, 64'd0);
        check("idle_rvalid_m0_stray", RVALID_M0, 64'd0);
        RVALID_S = 1'b0;

        // M0 alone, 4-beat burst at 0x1000.
        set_ar(1'b0, 4'h5, 32'h0000_1000, 4'd3);
        grant_phase(1'b0, 4'h5, 32'h0000_1000);
        check("arlen_s", ARLEN_S, 64'd3);
        addr_accept();
        r_beats(1'b0, 4, 32'hA0, 1'b1, 4'h5);
        check("after_burst_rready_s", RREADY_S, 64'd0);

        // Strict alternation with both requesting (ARLEN = 0), starting from reset.
        rst = 1'b1; #1; rst = 1'b0;
        set_ar(1'b0, 4'h1, 32'h100, 4'd0);
        set_ar(1'b1, 4'h2, 32'h200, 4'd0);
        for (int i = 0; i < 4; i++) begin
            bit m;
            m = (i % 2 == 1);
            grant_phase(m, m ? 4'h2 : 4'h1, m ? 32'h200 : 32'h100);
            addr_accept();
            r_beats(m, 1, 32'h10 * 32'(i), 1'b1, m ? 4'h2 : 4'h1);
            if (m) ARVALID_M1 = 1'b1; else ARVALID_M0 = 1'b1;
        end
        ARVALID_M0 = 1'b0;
        ARVALID_M1 = 1'b0;

        // Slave stalls AR for 5 cycles while M1 keeps requesting.
        set_ar(1'b0, 4'h7, 32'h2000, 4'd0);
        set_ar(1'b1, 4'h9, 32'h3000, 4'd3);
        grant_phase(1'b0, 4'h7, 32'h2000);
        ARADDR_M0 = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_arvalid_s",  ARVALID_S,  64'd1);
            check("stall_araddr_s",   ARADDR_S,   64'h2000);
            check("stall_arid_s",     ARID_S,     64'h07);
            check("stall_arready_m1", ARREADY_M1, 64'd0);
            cyc();
        end
        addr_accept();
        r_beats(1'b0, 1, 32'hC0, 1'b1, 4'h7);

        // M1 next; RREADY_M1 toggles during its 4-beat burst.
        grant_phase(1'b1, 4'h9, 32'h3000);
        addr_accept();
        beat = 0;
        for (int c = 0; c < 16 && beat < 4; c++) begin
            RVALID_S  = 1'b1;
            RDATA_S   = 32'hB0 + 32'(beat);
            RLAST_S   = (beat == 3);
            RID_S     = 8'h19;
            RREADY_M1 = (c % 2 == 0);
            #1;
            check("tog_rready_s", RREADY_S, 64'(RREADY_M1));
            check("tog_rvalid_m1", RVALID_M1, 64'd1);
            check("tog_rdata_m1", RDATA_M1, 64'(32'hB0 + 32'(beat)));
            hs = RREADY_M1;
            cyc();
            if (hs) beat++;
        end
        RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M1 = 1'b1;
        check("tog_beats_done", 64'(beat), 64'd4);
        #1;
        check("tog_back_idle_rready_s", RREADY_S, 64'd0);

        // Reset in the middle of beat 2 of 4.
        set_ar(1'b0, 4'h3, 32'h4000, 4'd3);
        grant_phase(1'b0, 4'h3, 32'h4000);
        addr_accept();
        r_beats(1'b0, 2, 32'hD0, 1'b0, 4'h3);
        RVALID_S = 1'b1; RDATA_S = 32'hD2; RID_S = 8'h03;
        #1;
        check("mid_rvalid_m0_pre", RVALID_M0, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid_m0", RVALID_M0, 64'd0);
        check("mid_rst_rdata_m0",  RDATA_M0,  64'd0);
        check("mid_rst_rready_s",  RREADY_S,  64'd0);
        check("mid_rst_arid_s",    ARID_S,    64'd0);
        check("mid_rst_araddr_s",  ARADDR_S,  64'd0);
        cyc();
        rst = 1'b0;
        RVALID_S = 1'b0;
        set_ar(1'b1, 4'h6, 32'h5000, 4'd0);
        grant_phase(1'b1, 4'h6, 32'h5000);
        addr_accept();
        r_beats(1'b1, 1, 32'hE0, 1'b1, 4'h6);

`ifdef ARB_TIMEOUT_EN
        // Slave accepts AR but never returns data within MAX_WAIT = 16 cycles.
        set_ar(1'b0, 4'hA, 32'h6000, 4'd0);
        grant_phase(1'b0, 4'hA, 32'h6000);
        addr_accept();
        k = 2;
        while (!RVALID_M0 && k < 40) begin
            cyc();
            k++;
        end
        check("to_err_cycle", 64'(k), 64'd17);
        check("to_rresp_m0", RRESP_M0, 64'h3);
        check("to_rlast_m0", RLAST_M0, 64'd1);
        check("to_rdata_m0", RDATA_M0, 64'd0);
        cyc();
        RVALID_S = 1'b1; RLAST_S = 1'b1; RDATA_S = 32'h55;
        #1;
        check("drain_rready_s",  RREADY_S,  64'd1);
        check("drain_rvalid_m0", RVALID_M0, 64'd0);
        cyc();
        RVALID_S = 1'b0; RLAST_S = 1'b0;
        #1;
        check("drain_done_rready_s", RREADY_S, 64'd0);
        check("drain_done_arvalid_s", ARVALID_S, 64'd0);
`else
        k = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master to one-slave arbiter for the AXI read path (AR + R channels). The CPU instruction port and the CPU data port share one read port into a slave-side interconnect segment or memory wrapper (ROM/IM/DM/DRAM).
- Round-robin grant. Only one outstanding burst at a time. The grant is held from the AR handshake until the last R beat has been handed back to its owner.

Parameters:
- ID_W, 4, master-side ARID/RID width
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 1023, cycle limit for the optional timeout (only used with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ARID_M0/ARID_M1  in  ID_W  master AR id
- ARADDR_M0/ARADDR_M1  in  ADDR_W  master AR address
- ARLEN_M0/ARLEN_M1  in  4  burst length-1
- ARSIZE_M0/ARSIZE_M1  in  3  beat size
- ARBURST_M0/ARBURST_M1  in  2  burst type
- ARVALID_M0/ARVALID_M1  in  1  master AR valid
- ARREADY_M0/ARREADY_M1  out  1  master AR ready
- RID_M0/RID_M1  out  ID_W  returned id
- RDATA_M0/RDATA_M1  out  DATA_W  returned data
- RRESP_M0/RRESP_M1  out  2  returned response
- RLAST_M0/RLAST_M1  out  1  last beat
- RVALID_M0/RVALID_M1  out  1  R valid to master
- RREADY_M0/RREADY_M1  in  1  R ready from master
- ARID_S  out  ID_W+4  {4-bit master tag, ARID}; tag 0 = M0, tag 1 = M1
- ARADDR_S  out  ADDR_W  slave AR address
- ARLEN_S  out  4  slave AR length
- ARSIZE_S  out  3  slave AR size
- ARBURST_S  out  2  slave AR burst
- ARVALID_S  out  1  slave AR valid
- ARREADY_S  in  1  slave AR ready
- RID_S  in  ID_W+4  slave R id
- RDATA_S  in  DATA_W  slave R data
- RRESP_S  in  2  slave R response
- RLAST_S  in  1  slave R last
- RVALID_S  in  1  slave R valid
- RREADY_S  out  1  R ready to slave

Behaviour:
- Reset values:
  - state = IDLE, prio = 0 (M0 favoured), owner = 0.
  - AR register cleared.
  - All VALID/READY outputs low. Data/id/resp outputs 0.
- IDLE:
  - Grant rule: grant = requester if exactly one ARVALID is high. If both are high, grant = prio.
  - ARREADY_Mgrant = 1 combinationally for that single cycle. The other ARREADY stays 0.
  - On the handshake: capture {tag, ARID, ADDR, LEN, SIZE, BURST} into the AR register, set owner = grant, go to ADDR.
  - No ARVALID → stay in IDLE.
- ADDR:
  - ARVALID_S = 1, driven from the AR register. Both ARREADY_Mx = 0.
  - ARREADY_S = 1 → DATA. Otherwise hold; register contents must stay stable.
- DATA:
  - RVALID_Mowner = RVALID_S and RREADY_S = RREADY_Mowner (combinational pass-through).
  - RDATA/RRESP/RLAST go to the owner. RID_Mowner = RID_S[ID_W-1:0].
  - Non-owner RVALID = 0; its data outputs = 0.
  - RVALID_S & RREADY_S & RLAST_S → IDLE, prio = ~owner.
- Latency:
  - AR accept to ARVALID_S: 1 cycle.
  - R path: 0 cycles.
  - Minimum gap between bursts: 1 IDLE cycle.
- Boundary conditions:
  - ARLEN = 0: the single beat with RLAST ends the burst.
  - Master deasserts ARVALID in IDLE before handshake: no grant is taken.
  - Simultaneous requests: alternate strictly, e.g. M0, M1, M0, ...
  - An R beat arriving outside DATA is ignored; RREADY_S = 0.
  - rst mid-burst: immediate return to reset values. Any in-flight slave beats are not consumed.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A 10-bit counter counts cycles spent in ADDR + DATA, cleared on entering ADDR.
  - Reaching MAX_WAIT → state ERR, which is one cycle with RVALID_Mowner = 1, RRESP = 2'b11 (DECERR), RLAST = 1, RDATA = 0.
  - The cycle holds until RREADY_Mowner, then → DRAIN.
  - DRAIN: RREADY_S = 1, masters see nothing. Exits to IDLE on an RLAST_S handshake, or immediately if the timeout fired in ADDR (no AR was accepted; ARVALID_S drops).
- Undefined: no counter; ADDR and DATA wait forever.

Decomposition:
- Shared package axi_arb_pkg:
  - state enum {IDLE, ADDR, DATA, ERR, DRAIN}
  - MTAG_M0 = 4'd0, MTAG_M1 = 4'd1
  - RESP_OKAY = 2'b00, RESP_DECERR = 2'b11
- Sub-module rr_picker2:
  - Inputs: req[1:0], prio.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational, reusable for the write-side arbiter.

Test Plan:
- M0 only, ARADDR = 0x0000_1000, ARLEN = 3, slave returns 4 beats with RREADY_M0 = 1:
  - ARID_S = {4'd0, ARID_M0}.
  - M0 gets 4 beats, RLAST on the 4th.
  - RVALID_M1 stays 0.
- M0 and M1 both valid from reset, ARLEN = 0:
  - M0 granted first, M1 granted next.
  - M1 and M0 both held valid again: M1 blocks M0 only via prio, so order is M0, M1, M0, M1.
- ARREADY_S held low 5 cycles:
  - ARVALID_S stays 1 and the AR register stays stable for 5 cycles.
  - ARREADY_M1 = 0 throughout, even though M1 is requesting.
- RREADY_M1 toggled 1/0 during a 4-beat burst:
  - RREADY_S mirrors it.
  - No beat is lost or duplicated; data order is preserved.
- rst asserted during DATA (beat 2 of 4):
  - All outputs go to reset values in the same cycle, asynchronously.
  - After release, a new M1 request is granted normally.
- ARB_TIMEOUT_EN, MAX_WAIT = 16, slave never responds after AR:
  - At cycle 16, M0 receives one DECERR beat with RLAST = 1.
  - A late slave RLAST beat is drained with RREADY_S = 1, then the FSM returns to IDLE.
